// File: rtl/uncache_pkg.sv
// Shared encodings for the MEM2 uncached access engine.
package uncache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem2_uncache_ctrl_if.sv
// SRAM-like data bus between the uncached engine (master) and the bus slave.
interface mem2_uncache_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  bus_req;
    logic                  bus_wr;
    logic [1:0]            bus_size;
    logic [ADDR_W-1:0]     bus_addr;
    logic [DATA_W/8-1:0]   bus_wstrb;
    logic [DATA_W-1:0]     bus_wdata;
    logic                  bus_addr_ok;
    logic                  bus_data_ok;
    logic [DATA_W-1:0]     bus_rdata;

    modport master (
        output bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/mem2_uncache_ctrl.sv
// Single-outstanding uncached load/store engine for MEM2; stalls the pipeline
// until the bus completes and holds the load word for MEM2->WB.
//
// state | meaning
// IDLE  | no access in flight; stall follows req_valid
// REQ   | bus_req asserted, waiting for addr_ok
// WAIT  | address accepted, waiting for data_ok
// DONE  | access complete, result held until the pipeline advances
module mem2_uncache_ctrl
    import uncache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_wr,
    input  logic [1:0]          req_size,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W/8-1:0] req_wstrb,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic                advance,
    output logic                stall,
    output logic [DATA_W-1:0]   rdata,
    output logic                rdata_valid,
    mem2_uncache_ctrl_if.master bus
);

    state_t state_q, state_d;
    logic   latch_req;
    logic   take_rdata;

    logic                bus_req_q;
    logic                bus_wr_q;
    logic [1:0]          bus_size_q;
    logic [ADDR_W-1:0]   bus_addr_q;
    logic [DATA_W/8-1:0] bus_wstrb_q;
    logic [DATA_W-1:0]   bus_wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                rdata_valid_q;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // DONE only leaves on advance, so a frozen pipeline never reissues the request.
    always_comb begin
        state_d    = state_q;
        latch_req  = 1'b0;
        take_rdata = 1'b0;
        case (state_q)
            ST_IDLE: if (req_valid) begin
                state_d   = ST_REQ;
                latch_req = 1'b1;
            end
            ST_REQ:  if (bus.bus_addr_ok) state_d = ST_WAIT;
            ST_WAIT: if (bus.bus_data_ok) begin
                state_d    = ST_DONE;
                take_rdata = 1'b1;
            end
            ST_DONE: if (advance) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        stall = rst & ((state_q == ST_IDLE && req_valid) ||
                       state_q == ST_REQ || state_q == ST_WAIT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus_req_q     <= 1'b0;
            bus_wr_q      <= 1'b0;
            bus_size_q    <= '0;
            bus_addr_q    <= '0;
            bus_wstrb_q   <= '0;
            bus_wdata_q   <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            if (latch_req) begin
                bus_req_q   <= 1'b1;
                bus_wr_q    <= req_wr;
                bus_size_q  <= req_size;
                bus_addr_q  <= req_addr;
                bus_wstrb_q <= req_wr ? req_wstrb : '0;
                bus_wdata_q <= req_wdata;
            end
            if (state_q == ST_REQ && bus.bus_addr_ok) bus_req_q <= 1'b0;
            if (take_rdata) begin
                rdata_valid_q <= !bus_wr_q;
                if (!bus_wr_q) rdata_q <= bus.bus_rdata;
            end
            if (state_q == ST_DONE && advance) rdata_valid_q <= 1'b0;
        end
    end

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_wr    = bus_wr_q;
    assign bus.bus_size  = bus_size_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wstrb = bus_wstrb_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign rdata         = rdata_q;
    assign rdata_valid   = rdata_valid_q;

endmodule

// File: tb/tb_mem2_uncache_ctrl.sv
// Directed self-checking bench for mem2_uncache_ctrl.
module tb_mem2_uncache_ctrl;
    import uncache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_wr, advance;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        stall, rdata_valid;
    logic [31:0] rdata;
    int          n_cmp = 0;
    int          n_err = 0;

    mem2_uncache_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bif ();

    mem2_uncache_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size),
        .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .advance(advance), .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
        .bus(bif.master)
    );

    always #5 clk = ~clk;

    // Inputs are driven 1 ns after the rising edge; outputs are sampled 2 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input logic v, input logic wr, input logic [1:0] sz,
                           input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd);
        req_valid = v; req_wr = wr; req_size = sz; req_addr = a; req_wstrb = ws; req_wdata = wd;
    endtask

    task automatic set_bus(input logic aok, input logic dok, input logic [31:0] rd);
        bif.bus_addr_ok = aok; bif.bus_data_ok = dok; bif.bus_rdata = rd;
    endtask

    task automatic test_reset();
        rst = 1'b0; advance = 1'b0;
        set_req(1'b1, 1'b1, SZ_WORD, 32'h1234_5678, 4'hF, 32'hCAFE_F00D);
        set_bus(1'b0, 1'b0, 32'h0);
        step(); step(); settle();
        if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_cmp++;
        if (bif.bus_req !== 1'b0 || bif.bus_addr !== 32'h0 || bif.bus_wstrb !== 4'h0)
        begin n_err++; $display("FAIL reset_bus: req %b addr %h wstrb %h want 0", bif.bus_req, bif.bus_addr, bif.bus_wstrb); end
        n_cmp++;
        if (dut.state_q !== ST_IDLE || rdata_valid !== 1'b0 || rdata !== 32'h0)
        begin n_err++; $display("FAIL reset_state: state %0d rv %b rdata %h", dut.state_q, rdata_valid, rdata); end
        n_cmp++;
        step();
        rst = 1'b1; set_req(1'b0, 1'b0, SZ_BYTE, 32'h0, 4'h0, 32'h0);
        step();
    endtask

    task automatic test_word_load();
        // cycle 0: IDLE with request
        set_req(1'b1, 1'b0, SZ_WORD, 32'h1FAF_0000, 4'hF, 32'h0); settle();
        if (stall !== 1'b1) begin n_err++; $display("FAIL load_stall_c0: got %b want 1", stall); end
        n_cmp++;
        step(); set_bus(1'b1, 1'b0, 32'h0); settle();
        if (stall !== 1'b1 || bif.bus_req !== 1'b1) begin n_err++; $display("FAIL load_c1: stall %b req %b want 1 1", stall, bif.bus_req); end
        n_cmp++;
        if (bif.bus_addr !== 32'h1FAF_0000 || bif.bus_size !== SZ_WORD || bif.bus_wr !== 1'b0 || bif.bus_wstrb !== 4'h0)
        begin n_err++; $display("FAIL load_bus: addr %h size %0d wr %b wstrb %h", bif.bus_addr, bif.bus_size, bif.bus_wr, bif.bus_wstrb); end
        n_cmp++;
        step(); set_bus(1'b0, 1'b1, 32'hDEAD_BEEF); settle();
        if (stall !== 1'b1 || bif.bus_req !== 1'b0 || dut.state_q !== ST_WAIT)
        begin n_err++; $display("FAIL load_c2: stall %b req %b state %0d want 1 0 2", stall, bif.bus_req, dut.state_q); end
        n_cmp++;
        step(); set_bus(1'b0, 1'b0, 32'h0); advance = 1'b1; settle();
        if (stall !== 1'b0 || rdata !== 32'hDEAD_BEEF || rdata_valid !== 1'b1)
        begin n_err++; $display("FAIL load_c3: stall %b rdata %h rv %b want 0 deadbeef 1", stall, rdata, rdata_valid); end
        n_cmp++;
        step(); advance = 1'b0; set_req(1'b0, 1'b0, SZ_BYTE, 32'h0, 4'h0, 32'h0); settle();
        if (dut.state_q !== ST_IDLE || rdata_valid !== 1'b0)
        begin n_err++; $display("FAIL load_c4: state %0d rv %b want 0 0", dut.state_q, rdata_valid); end
        n_cmp++;
    endtask

    task automatic test_store_wait();
        set_req(1'b1, 1'b1, SZ_BYTE, 32'h1FAF_0002, 4'b0100, 32'h00AB_0000); settle();
        // three REQ cycles without addr_ok, with req_* disturbed to prove the bus is registered
        for (int i = 1; i <= 4; i++) begin
            step();
            set_req(1'b1, 1'b1, SZ_WORD, 32'hFFFF_FFF0 + i, 4'hF, 32'h5555_0000 + i);
            set_bus(i == 4, 1'b0, 32'h0); settle();
            if (bif.bus_req !== 1'b1 || bif.bus_wr !== 1'b1 || bif.bus_size !== SZ_BYTE || bif.bus_addr !== 32'h1FAF_0002 ||
                bif.bus_wstrb !== 4'b0100 || bif.bus_wdata !== 32'h00AB_0000 || stall !== 1'b1)
            begin n_err++; $display("FAIL store_req_c%0d: req %b wr %b sz %0d addr %h ws %b wd %h stall %b", i,
                bif.bus_req, bif.bus_wr, bif.bus_size, bif.bus_addr, bif.bus_wstrb, bif.bus_wdata, stall); end
            n_cmp++;
        end
        for (int i = 5; i <= 7; i++) begin
            step(); set_bus(1'b0, i == 7, 32'h7777_7777); settle();
            if (stall !== 1'b1 || bif.bus_req !== 1'b0) begin n_err++; $display("FAIL store_wait_c%0d: stall %b req %b want 1 0", i, stall, bif.bus_req); end
            n_cmp++;
        end
        step(); set_bus(1'b0, 1'b0, 32'h0); advance = 1'b1; settle();
        if (stall !== 1'b0 || rdata_valid !== 1'b0 || rdata !== 32'hDEAD_BEEF)
        begin n_err++; $display("FAIL store_done: stall %b rv %b rdata %h want 0 0 deadbeef", stall, rdata_valid, rdata); end
        n_cmp++;
        step(); advance = 1'b0; set_req(1'b0, 1'b0, SZ_BYTE, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic test_frozen();
        set_req(1'b1, 1'b0, SZ_WORD, 32'h1FAF_0010, 4'h0, 32'h0);
        step(); set_bus(1'b1, 1'b0, 32'h0);
        step(); set_bus(1'b0, 1'b1, 32'h1234_5678);
        step(); set_bus(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            settle();
            if (bif.bus_req !== 1'b0 || stall !== 1'b0 || rdata !== 32'h1234_5678 || rdata_valid !== 1'b1 || dut.state_q !== ST_DONE)
            begin n_err++; $display("FAIL frozen_c%0d: req %b stall %b rdata %h rv %b state %0d", i,
                bif.bus_req, stall, rdata, rdata_valid, dut.state_q); end
            n_cmp++;
            step();
        end
        advance = 1'b1;
        step(); advance = 1'b0; set_req(1'b0, 1'b0, SZ_BYTE, 32'h0, 4'h0, 32'h0); settle();
        if (dut.state_q !== ST_IDLE || rdata_valid !== 1'b0 || bif.bus_req !== 1'b0)
        begin n_err++; $display("FAIL frozen_release: state %0d rv %b req %b want 0 0 0", dut.state_q, rdata_valid, bif.bus_req); end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] seen [$];
        logic        exp_req [8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        exp_stall [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 8; c++) begin
            if (c <= 2) set_req(1'b1, 1'b0, SZ_WORD, 32'h1FD0_F000, 4'h0, 32'h0);
            else if (c <= 6) set_req(1'b1, 1'b0, SZ_WORD, 32'h1FD0_F004, 4'h0, 32'h0);
            else set_req(1'b1, 1'b0, SZ_WORD, 32'h1FD0_F008, 4'h0, 32'h0);
            set_bus(c == 1 || c == 5, c == 2 || c == 6, (c == 2) ? 32'h1111_1111 : 32'h2222_2222);
            advance = (c == 3 || c == 7);
            settle();
            if (bif.bus_req) seen.push_back(bif.bus_addr);
            if (bif.bus_req !== exp_req[c] || stall !== exp_stall[c])
            begin n_err++; $display("FAIL b2b_c%0d: req %b stall %b want %b %b", c, bif.bus_req, stall, exp_req[c], exp_stall[c]); end
            n_cmp++;
            if (c == 3 && rdata !== 32'h1111_1111) begin n_err++; $display("FAIL b2b_rdata1: got %h want 11111111", rdata); end
            if (c == 3) n_cmp++;
            if (c == 7 && (rdata !== 32'h2222_2222 || rdata_valid !== 1'b1))
            begin n_err++; $display("FAIL b2b_rdata2: got %h rv %b want 22222222 1", rdata, rdata_valid); end
            if (c == 7) n_cmp++;
            step();
        end
        advance = 1'b0; set_req(1'b0, 1'b0, SZ_BYTE, 32'h0, 4'h0, 32'h0); set_bus(1'b0, 1'b0, 32'h0);
        if (seen.size() != 2 || seen[0] !== 32'h1FD0_F000 || seen[1] !== 32'h1FD0_F004)
        begin n_err++; $display("FAIL b2b_order: %0d requests, first %h second %h", seen.size(),
            (seen.size() > 0) ? seen[0] : 32'h0, (seen.size() > 1) ? seen[1] : 32'h0); end
        n_cmp++;
        step();
    endtask

    task automatic test_reset_in_wait();
        set_req(1'b1, 1'b1, SZ_HALF, 32'h1FAF_0020, 4'b0011, 32'h0000_BEEF);
        step(); set_bus(1'b1, 1'b0, 32'h0);
        step(); set_bus(1'b0, 1'b0, 32'h0); rst = 1'b0;
        step(); rst = 1'b1; set_req(1'b0, 1'b0, SZ_BYTE, 32'h0, 4'h0, 32'h0); set_bus(1'b0, 1'b1, 32'hBAD0_BAD0); settle();
        if (dut.state_q !== ST_IDLE || stall !== 1'b0 || bif.bus_req !== 1'b0 || bif.bus_wr !== 1'b0 ||
            bif.bus_size !== 2'd0 || bif.bus_addr !== 32'h0 || bif.bus_wstrb !== 4'h0 || bif.bus_wdata !== 32'h0 ||
            rdata !== 32'h0 || rdata_valid !== 1'b0)
        begin n_err++; $display("FAIL rst_wait: state %0d stall %b req %b wr %b sz %0d addr %h ws %h wd %h rdata %h rv %b",
            dut.state_q, stall, bif.bus_req, bif.bus_wr, bif.bus_size, bif.bus_addr, bif.bus_wstrb, bif.bus_wdata, rdata, rdata_valid); end
        n_cmp++;
        step(); set_bus(1'b0, 1'b0, 32'h0); settle();
        if (dut.state_q !== ST_IDLE || rdata !== 32'h0 || rdata_valid !== 1'b0 || stall !== 1'b0)
        begin n_err++; $display("FAIL rst_late_data_ok: state %0d rdata %h rv %b stall %b", dut.state_q, rdata, rdata_valid, stall); end
        n_cmp++;
    endtask

    task automatic test_spurious_data_ok();
        set_req(1'b1, 1'b0, SZ_WORD, 32'h1FAF_0030, 4'h0, 32'h0);
        step(); set_bus(1'b0, 1'b1, 32'hBADB_ADBA);
        step(); set_bus(1'b1, 1'b0, 32'h0); settle();
        if (dut.state_q !== ST_REQ || bif.bus_req !== 1'b1 || rdata_valid !== 1'b0 || stall !== 1'b1)
        begin n_err++; $display("FAIL spurious_req: state %0d req %b rv %b stall %b want 1 1 0 1", dut.state_q, bif.bus_req, rdata_valid, stall); end
        n_cmp++;
        step(); set_bus(1'b0, 1'b1, 32'hA5A5_5A5A);
        step(); set_bus(1'b0, 1'b0, 32'h0); advance = 1'b1; settle();
        if (rdata !== 32'hA5A5_5A5A || rdata_valid !== 1'b1 || stall !== 1'b0)
        begin n_err++; $display("FAIL spurious_done: rdata %h rv %b stall %b want a5a55a5a 1 0", rdata, rdata_valid, stall); end
        n_cmp++;
        step(); advance = 1'b0; set_req(1'b0, 1'b0, SZ_BYTE, 32'h0, 4'h0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_store_wait();
        test_frozen();
        test_back_to_back();
        test_reset_in_wait();
        test_spurious_data_ok();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
